// File: rtl/ecpeta_pipe_adder.sv
// Error-compensated approximate adder with per-transaction depth; 2-stage valid/ready pipe, result 2 cycles after accept.
// Stalls hold out_* stable; optional error monitor enabled by ECPETA_ERRSTAT_EN.
module ecpeta_pipe_adder #(
  parameter int N    = 16,
  parameter int LMAX = 8,
  parameter int LW   = $clog2(N),
  parameter int CW   = 16,
  parameter int AW   = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [LW-1:0] in_l,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_sum,
  output logic          out_cout,
  output logic [LW-1:0] out_l,
  input  logic          stat_clr,
  output logic [CW-1:0] err_cnt,
  output logic [AW-1:0] err_acc
);

  logic          s1_valid, s2_valid, s1_adv, s2_adv;
  logic [N-1:0]  s1_a, s1_b;
  logic [LW-1:0] s1_l, l_san;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Depths below 3 collapse to exact mode; oversize requests clamp to LMAX.
  always_comb begin
    if (in_l < LW'(3))         l_san = '0;
    else if (in_l > LW'(LMAX)) l_san = LW'(LMAX);
    else                       l_san = in_l;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_l     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= in_a;
        s1_b <= in_b;
        s1_l <= l_san;
      end
    end
  end

  logic [N-1:0] g, lo;
  logic         cin, orr;
  logic [N:0]   up, res;
  int           lv;

  always_comb begin
    lv  = int'(s1_l);
    g   = s1_a & s1_b;
    cin = 1'b0;
    orr = 1'b0;
    lo  = '0;
    for (int i = 0; i < LMAX; i++)
      if (i == lv - 1 || i == lv - 2) cin = cin | g[i];
    // Walk downward so orr holds the generates strictly above bit i (up to L-2).
    for (int i = LMAX - 1; i >= 0; i--) begin
      if (i == lv - 1) begin
        lo[i] = (s1_a[i] | s1_b[i]) & ~cin;
      end else if (i < lv - 1) begin
        lo[i] = s1_a[i] | s1_b[i] | orr;
        orr   = orr | g[i];
      end
    end
    up  = (({1'b0, s1_a} >> s1_l) + ({1'b0, s1_b} >> s1_l) + (N+1)'(cin)) << s1_l;
    res = up | {1'b0, lo};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_l    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sum  <= res[N-1:0];
        out_cout <= res[N];
        out_l    <= s1_l;
      end
    end
  end

`ifdef ECPETA_ERRSTAT_EN
  logic [N:0]  exact, d1, s2_d;
  logic [AW:0] acc_sum;

  assign exact   = {1'b0, s1_a} + {1'b0, s1_b};
  assign d1      = (exact >= res) ? (exact - res) : (res - exact);
  assign acc_sum = {1'b0, err_acc} + (AW+1)'(s2_d);

  always_ff @(posedge clk) begin
    if (!rst_n)                    s2_d <= '0;
    else if (s2_adv && s1_valid)   s2_d <= d1;
  end

  // Clear beats a coincident handshake; its error is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      err_cnt <= '0;
      err_acc <= '0;
    end else if (out_valid && out_ready && s2_d != '0) begin
      if (err_cnt != '1) err_cnt <= err_cnt + CW'(1);
      err_acc <= acc_sum[AW] ? '1 : acc_sum[AW-1:0];
    end
  end
`else
  logic stat_clr_unused;
  assign stat_clr_unused = stat_clr;
  assign err_cnt = '0;
  assign err_acc = '0;
`endif

endmodule

// File: tb/tb_ecpeta_pipe_adder.sv
// Scoreboard bench for ecpeta_pipe_adder: directed vectors with hand-computed results.
module tb_ecpeta_pipe_adder;
  localparam int N = 16, LW = 4, CW = 16, AW = 24;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b1, stat_clr = 1'b0;
  logic [N-1:0]  in_a = '0, in_b = '0;
  logic [LW-1:0] in_l = '0;
  logic          in_ready, out_valid, out_cout;
  logic [N-1:0]  out_sum;
  logic [LW-1:0] out_l;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] err_acc;

  int total = 0, bad = 0, hs_cnt = 0;

  typedef struct packed {
    logic [N-1:0]  sum;
    logic          cout;
    logic [LW-1:0] l;
    logic [N:0]    d;
  } exp_t;
  exp_t q[$];
  logic [CW-1:0] m_cnt = '0;
  logic [AW-1:0] m_acc = '0;

  always #5 clk = ~clk;

  ecpeta_pipe_adder #(.N(N), .LMAX(8), .CW(CW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_l(in_l), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_l(out_l),
    .stat_clr(stat_clr), .err_cnt(err_cnt), .err_acc(err_acc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each output handshake and tracks the counter model.
  always @(negedge clk) begin
    exp_t e;
    logic [AW:0] t;
    if (!rst_n) begin
      q.delete();
      m_cnt = '0;
      m_acc = '0;
    end else begin
      e = '0;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (q.size() == 0) begin
          check("unexpected_out", {16'h0, out_sum}, 32'hDEAD);
        end else begin
          e = q.pop_front();
          check("sum", {16'h0, out_sum}, {16'h0, e.sum});
          check("cout", {31'h0, out_cout}, {31'h0, e.cout});
          check("out_l", {28'h0, out_l}, {28'h0, e.l});
        end
      end
`ifdef ECPETA_ERRSTAT_EN
      if (stat_clr) begin
        m_cnt = '0;
        m_acc = '0;
      end else if (out_valid && out_ready && e.d != '0) begin
        if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        t = {1'b0, m_acc} + (AW+1)'(e.d);
        m_acc = t[AW] ? '1 : t[AW-1:0];
      end
`endif
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [LW-1:0] l,
                      input logic [N-1:0] es, input logic ec, input logic [LW-1:0] el,
                      input logic [N:0] ed);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_l = l;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", {31'h0, in_ready}, 32'h1);
    end else begin
      @(posedge clk);
      e.sum = es; e.cout = ec; e.l = el; e.d = ed;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_stats(input string name);
    check({name, "_cnt"}, {16'h0, err_cnt}, {16'h0, m_cnt});
    check({name, "_acc"}, {8'h0, err_acc}, {8'h0, m_acc});
  endtask

  initial begin
    int c0, n;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_sum", {16'h0, out_sum}, 32'h0);
    check("rst_out_cout", {31'h0, out_cout}, 32'h0);
    check("rst_out_l", {28'h0, out_l}, 32'h0);
    check("rst_err_cnt", {16'h0, err_cnt}, 32'h0);
    check("rst_err_acc", {8'h0, err_acc}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", {31'h0, in_ready}, 32'h1);

    // Latency: result exactly two cycles after accept.
    send(16'h00FF, 16'h0001, 4'd8, 16'h00FF, 1'b0, 4'd8, 17'd1);
    @(negedge clk); in_valid = 1'b0;
    check("lat_not_early", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    check("lat_two_cycles", {31'h0, out_valid}, 32'h1);
    idle(3);
    check_stats("t1");

    // Assorted depths, back-to-back with differing L.
    send(16'h00C0, 16'h00C0, 4'd8,  16'h017F, 1'b0, 4'd8, 17'd1);
    send(16'hFFFF, 16'h0001, 4'd1,  16'h0000, 1'b1, 4'd0, 17'd0);
    send(16'hFFFF, 16'h0001, 4'd15, 16'hFFFF, 1'b0, 4'd8, 17'd1);
    send(16'h0006, 16'h0006, 4'd3,  16'h000B, 1'b0, 4'd3, 17'd1);
    send(16'h1234, 16'h0101, 4'd4,  16'h1335, 1'b0, 4'd4, 17'd0);
    send(16'h0003, 16'h0003, 4'd5,  16'h0003, 1'b0, 4'd5, 17'd3);
    send(16'h00F0, 16'h0010, 4'd9,  16'h00FF, 1'b0, 4'd8, 17'd1);
    send(16'hABCD, 16'h1111, 4'd2,  16'hBCDE, 1'b0, 4'd0, 17'd0);
    idle(4);
    check_stats("t2");

    // Backpressure: two accepted, then stall with outputs frozen.
    out_ready = 1'b0;
    send(16'h00FF, 16'h0001, 4'd8, 16'h00FF, 1'b0, 4'd8, 17'd1);
    send(16'h1234, 16'h0101, 4'd4, 16'h1335, 1'b0, 4'd4, 17'd0);
    @(negedge clk);
    in_a = 16'h0006; in_b = 16'h0006; in_l = 4'd3;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", {31'h0, in_ready}, 32'h0);
      check("stall_out_valid", {31'h0, out_valid}, 32'h1);
      check("stall_out_sum", {16'h0, out_sum}, 32'h00FF);
      @(negedge clk);
    end
    c0 = hs_cnt;
    @(posedge clk); #1 out_ready = 1'b1;
    send(16'h0006, 16'h0006, 4'd3, 16'h000B, 1'b0, 4'd3, 17'd1);
    send(16'hFFFF, 16'h0001, 4'd2, 16'h0000, 1'b1, 4'd0, 17'd0);
    #1 in_valid = 1'b0;
    check("burst_valid_a", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;
    check("burst_valid_b", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;
    check("burst_drained", {31'h0, out_valid}, 32'h0);
    check("burst_count", hs_cnt - c0, 32'd4);
    idle(2);
    check_stats("t4");

    // Reset with two transactions in flight: nothing emerges afterwards.
    send(16'h00C0, 16'h00C0, 4'd8, 16'h017F, 1'b0, 4'd8, 17'd1);
    send(16'h0006, 16'h0006, 4'd3, 16'h000B, 1'b0, 4'd3, 17'd1);
    #1 rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_out_sum", {16'h0, out_sum}, 32'h0);
    check("mid_rst_err_cnt", {16'h0, err_cnt}, 32'h0);
    check("mid_rst_err_acc", {8'h0, err_acc}, 32'h0);
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    c0 = hs_cnt;
    repeat (6) @(negedge clk);
    check("mid_rst_no_output", hs_cnt - c0, 32'd0);

    // Clear coincident with an erroneous handshake.
    send(16'h00FF, 16'h0001, 4'd8, 16'h00FF, 1'b0, 4'd8, 17'd1);
    idle(3);
    check_stats("t6_pre");
    send(16'h00C0, 16'h00C0, 4'd8, 16'h017F, 1'b0, 4'd8, 17'd1);
    #1 in_valid = 1'b0;
    @(posedge clk); #1 stat_clr = 1'b1;
    @(posedge clk); #1 stat_clr = 1'b0;
    @(negedge clk);
    check("clr_err_cnt", {16'h0, err_cnt}, 32'h0);
    check("clr_err_acc", {8'h0, err_acc}, 32'h0);

`ifdef ECPETA_ERRSTAT_EN
    for (int i = 0; i < 65540; i++)
      send(16'h00FF, 16'h0001, 4'd8, 16'h00FF, 1'b0, 4'd8, 17'd1);
    idle(4);
    check("sat_err_cnt", {16'h0, err_cnt}, 32'h0000FFFF);
    check("sat_err_acc", {8'h0, err_acc}, 32'h00010004);
`else
    send(16'h00FF, 16'h0001, 4'd8, 16'h00FF, 1'b0, 4'd8, 17'd1);
    idle(4);
    check("tied_err_cnt", {16'h0, err_cnt}, 32'h0);
    check("tied_err_acc", {8'h0, err_acc}, 32'h0);
`endif

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
